// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: word width, reset/bubble encodings,
// fetch FSM states and the PC increment helper.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DFLT  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DFLT = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // 32-bit modulo: 32'hFFFF_FFFC wraps to zero
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: ID-stage control, instruction-memory handshake and the
// IF outputs feeding the if_id pipeline register.
interface if_fetch_if;
    import mips_pkg::*;

    logic              stall;
    logic              br_taken;
    logic [WORD_W-1:0] br_target;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_data;
    logic [WORD_W-1:0] IF_ir;
    logic [WORD_W-1:0] IF_npc;
    logic              IF_valid;

    modport master (
        input  stall, br_taken, br_target, imem_ack, imem_data,
        output imem_req, imem_addr, IF_ir, IF_npc, IF_valid
    );

    modport slave (
        output stall, br_taken, br_target, imem_ack, imem_data,
        input  imem_req, imem_addr, IF_ir, IF_npc, IF_valid
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry parking slot for an instruction that arrived while ID was stalled.
// Clear wins over load so a redirect always discards the parked word.
module if_hold_buf
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] ir_i,
    input  logic [WORD_W-1:0] npc_i,
    output logic [WORD_W-1:0] ir_o,
    output logic [WORD_W-1:0] npc_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] ir_q;
    logic [WORD_W-1:0] npc_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q    <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            ir_q    <= ir_i;
            npc_q   <= npc_i;
            valid_q <= 1'b1;
        end
    end

    assign ir_o    = ir_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues imem requests and registers
// IF_ir/IF_npc/IF_valid for if_id. All outputs come straight from flops.
//
//   state    | meaning
//   ST_IDLE  | first cycle after reset release, no request
//   ST_FETCH | request out at pc, capture/bubble on each edge
//   ST_HOLD  | ID stalled with a word parked in the hold buffer
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DFLT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic              valid_q, valid_d;
    logic              req_q;

    logic              buf_load, buf_clear, buf_valid;
    logic [WORD_W-1:0] buf_ir, buf_npc;
    logic [WORD_W-1:0] pc_inc_w;

    assign pc_inc_w = pc_inc(pc_q);

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .ir_i    (bus.imem_data),
        .npc_i   (pc_inc_w),
        .ir_o    (buf_ir),
        .npc_o   (buf_npc),
        .valid_o (buf_valid)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        npc_d     = npc_q;
        valid_d   = valid_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        // Redirect overrides stall, ack and any parked word
        if (bus.br_taken) begin
            pc_d      = bus.br_target & ~32'h3;
            buf_clear = 1'b1;
            ir_d      = NOP_INSTR;
            valid_d   = 1'b0;
            state_d   = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.stall) begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end else begin
                            ir_d    = bus.imem_data;
                            npc_d   = pc_inc_w;
                            valid_d = 1'b1;
                            pc_d    = pc_inc_w;
                        end
                    end else if (!bus.stall) begin
                        ir_d    = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall && buf_valid) begin
                        ir_d      = buf_ir;
                        npc_d     = buf_npc;
                        valid_d   = 1'b1;
                        pc_d      = pc_inc_w;
                        buf_clear = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            req_q   <= (state_d == ST_FETCH);
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.IF_ir     = ir_q;
    assign bus.IF_npc    = npc_q;
    assign bus.IF_valid  = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a random run, all checked against
// a transaction-level model of the fetch stream.
module tb_if_fetch;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if bus ();
    if_fetch_if bus2 ();

    if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    // Wrap instance: memory always answers with its own address
    assign bus2.stall     = 1'b0;
    assign bus2.br_taken  = 1'b0;
    assign bus2.br_target = 32'h0;
    assign bus2.imem_ack  = 1'b1;
    assign bus2.imem_data = bus2.imem_addr;

    localparam logic [31:0] NOP = 32'h0000_0000;

    int checks = 0;
    int errors = 0;

    // Model: next address, current IF outputs, parked words, and whether the
    // one dead cycle after reset is still pending.
    logic [31:0] m_pc, m_ir, m_npc;
    bit          m_valid, m_idle, scramble;
    logic [63:0] m_held[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? ((a * 32'h9E37_79B9) ^ 32'h1234_5678) : a;
    endfunction

    function automatic bit m_req();
        return !m_idle && (m_held.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ir = NOP; m_npc = 32'h0; m_valid = 1'b0; m_idle = 1'b1;
        m_held.delete();
    endtask

    task automatic model_step(input bit ack, input bit stall, input bit br, input logic [31:0] tgt);
        logic [63:0] e;
        if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_held.delete();
            m_ir = NOP; m_valid = 1'b0; m_idle = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                e = m_held.pop_front();
                m_ir = e[63:32]; m_npc = e[31:0]; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (ack && !stall) begin
            m_ir = mem_word(m_pc); m_npc = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else if (ack) begin
            m_held.push_back({mem_word(m_pc), m_pc + 32'd4});
        end else if (!stall) begin
            m_ir = NOP; m_valid = 1'b0;
        end
    endtask

    // Drives one cycle's inputs, advances the model at the edge, returns at negedge.
    task automatic drive_cycle(input bit ack, input bit stall, input bit br, input logic [31:0] tgt);
        bus.imem_ack  = ack;
        bus.stall     = stall;
        bus.br_taken  = br;
        bus.br_target = tgt;
        bus.imem_data = ack ? mem_word(m_pc) : $urandom();
        @(posedge clk);
        model_step(ack, stall, br, tgt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = 32'h0; bus.imem_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (bus.IF_ir !== NOP) begin errors++; $display("FAIL reset IF_ir got %h want %h", bus.IF_ir, NOP); end
        if (bus.IF_npc !== 32'h0) begin errors++; $display("FAIL reset IF_npc got %h want 0", bus.IF_npc); end
        if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL reset IF_valid got %b want 0", bus.IF_valid); end
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset imem_req got %b want 0", bus.imem_req); end
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset imem_addr got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_stream();
        scramble = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            checks += 5;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL stream ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_npc !== m_npc) begin errors++; $display("FAIL stream npc c%0d got %h want %h", c, bus.IF_npc, m_npc); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL stream valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_req !== m_req()) begin errors++; $display("FAIL stream req c%0d got %b want %b", c, bus.imem_req, m_req()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL stream addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
        end
    endtask

    task automatic test_ack_gap();
        logic [7:0] acks;
        acks = 8'b1110_0110;  // cycle 0 first: idle, ack@0, ack@4, gap x2 at 8, ack x3
        scramble = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(acks[c], 1'b0, 1'b0, 32'h0);
            checks += 4;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL gap ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_npc !== m_npc) begin errors++; $display("FAIL gap npc c%0d got %h want %h", c, bus.IF_npc, m_npc); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL gap valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL gap addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
            if (c == 5) begin
                checks += 2;
                if (bus.IF_ir !== 32'h8) begin errors++; $display("FAIL gap resume ir got %h want 00000008", bus.IF_ir); end
                if (bus.IF_npc !== 32'hC) begin errors++; $display("FAIL gap resume npc got %h want 0000000c", bus.IF_npc); end
            end
        end
    endtask

    task automatic test_stall_hold();
        logic [1:0] tbl [0:10];  // {ack, stall}
        tbl = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10};
        scramble = 1'b0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive_cycle(tbl[c][1], tbl[c][0], 1'b0, 32'h0);
            checks += 5;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL hold ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_npc !== m_npc) begin errors++; $display("FAIL hold npc c%0d got %h want %h", c, bus.IF_npc, m_npc); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL hold valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_req !== m_req()) begin errors++; $display("FAIL hold req c%0d got %b want %b", c, bus.imem_req, m_req()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL hold addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
            if (c == 8) begin
                checks += 3;
                if (bus.IF_ir !== 32'h10) begin errors++; $display("FAIL hold release ir got %h want 00000010", bus.IF_ir); end
                if (bus.IF_npc !== 32'h14) begin errors++; $display("FAIL hold release npc got %h want 00000014", bus.IF_npc); end
                if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL hold release addr got %h want 00000014", bus.imem_addr); end
            end
        end
    endtask

    task automatic test_redirect();
        logic [2:0] tbl [0:7];  // {ack, stall, br}
        tbl = '{3'b000, 3'b100, 3'b100, 3'b110, 3'b011, 3'b100, 3'b100, 3'b100};
        scramble = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(tbl[c][2], tbl[c][1], tbl[c][0], 32'h0000_0103);
            checks += 4;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL redir ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL redir valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_req !== m_req()) begin errors++; $display("FAIL redir req c%0d got %b want %b", c, bus.imem_req, m_req()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL redir addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
            if (c == 4) begin
                checks += 3;
                if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL redir bubble valid got %b want 0", bus.IF_valid); end
                if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir target addr got %h want 00000100", bus.imem_addr); end
                if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL redir target req got %b want 1", bus.imem_req); end
            end
            if (c >= 4) begin
                checks++;
                if (bus.IF_ir === 32'h8) begin errors++; $display("FAIL redir parked word leaked got %h want not 00000008", bus.IF_ir); end
            end
            if (c == 5) begin
                checks++;
                if (bus.IF_ir !== 32'h100) begin errors++; $display("FAIL redir first ir got %h want 00000100", bus.IF_ir); end
            end
        end
    endtask

    task automatic test_random();
        bit ack, stall, br;
        logic [31:0] tgt;
        scramble = 1'b1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ack   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 19) == 0);
            tgt   = $urandom();
            drive_cycle(ack, stall, br, tgt);
            checks += 5;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL rand ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_npc !== m_npc) begin errors++; $display("FAIL rand npc c%0d got %h want %h", c, bus.IF_npc, m_npc); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL rand valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_req !== m_req()) begin errors++; $display("FAIL rand req c%0d got %b want %b", c, bus.imem_req, m_req()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rand addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
        end
        scramble = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] e_ir [0:4];
        logic [31:0] e_npc [0:4];
        logic [31:0] e_addr [0:4];
        logic        e_valid [0:4];
        e_ir    = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        e_npc   = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
        e_addr  = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        e_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
            checks += 4;
            if (bus2.IF_ir !== e_ir[k]) begin errors++; $display("FAIL wrap ir k%0d got %h want %h", k, bus2.IF_ir, e_ir[k]); end
            if (bus2.IF_npc !== e_npc[k]) begin errors++; $display("FAIL wrap npc k%0d got %h want %h", k, bus2.IF_npc, e_npc[k]); end
            if (bus2.IF_valid !== e_valid[k]) begin errors++; $display("FAIL wrap valid k%0d got %b want %b", k, bus2.IF_valid, e_valid[k]); end
            if (bus2.imem_addr !== e_addr[k]) begin errors++; $display("FAIL wrap addr k%0d got %h want %h", k, bus2.imem_addr, e_addr[k]); end
        end
    endtask

    task automatic test_rst_mid();
        scramble = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (bus.IF_valid !== 1'b0) begin errors++; $display("FAIL rstmid valid got %b want 0", bus.IF_valid); end
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rstmid req got %b want 0", bus.imem_req); end
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rstmid addr got %h want 0", bus.imem_addr); end
        if (bus.IF_ir !== NOP) begin errors++; $display("FAIL rstmid ir got %h want %h", bus.IF_ir, NOP); end
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            checks += 4;
            if (bus.IF_ir !== m_ir) begin errors++; $display("FAIL rstmid ir c%0d got %h want %h", c, bus.IF_ir, m_ir); end
            if (bus.IF_valid !== m_valid) begin errors++; $display("FAIL rstmid valid c%0d got %b want %b", c, bus.IF_valid, m_valid); end
            if (bus.imem_req !== m_req()) begin errors++; $display("FAIL rstmid req c%0d got %b want %b", c, bus.imem_req, m_req()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rstmid addr c%0d got %h want %h", c, bus.imem_addr, m_pc); end
            if (c == 1) begin
                checks++;
                if (bus.IF_ir !== 32'h0 || bus.IF_valid !== 1'b1) begin
                    errors++; $display("FAIL rstmid restart got ir %h valid %b want ir 00000000 valid 1", bus.IF_ir, bus.IF_valid);
                end
            end
        end
    endtask

    initial begin
        scramble = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_ack_gap();
        test_stall_hold();
        test_redirect();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
